// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: requester index map and the tag/data widths used by
// the tag FIFO, the reservation stations and the CDB arbiter.
package cdb_arbiter_pkg;

   localparam int CDB_TAG_WIDTH  = 6;
   localparam int CDB_DATA_WIDTH = 32;
   localparam int CDB_NUM_REQ    = 4;

   typedef enum logic [1:0] {
      CDB_INT = 2'd0,
      CDB_MUL = 2'd1,
      CDB_DIV = 2'd2,
      CDB_LS  = 2'd3
   } cdb_unit_e;

   // Index of the asserted bit of a one-hot 4-bit grant (0 when none is set).
   function automatic logic [1:0] cdb_onehot_idx(input logic [3:0] oh);
      cdb_unit_e idx;
      if (oh[1])      idx = CDB_MUL;
      else if (oh[2]) idx = CDB_DIV;
      else if (oh[3]) idx = CDB_LS;
      else            idx = CDB_INT;
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant: rotate the requests so ptr sits at bit 0, pick
// the lowest set bit, then rotate the one-hot result back.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt
);

   logic [3:0] w_rot;
   logic [3:0] w_rot_gnt;
   logic [1:0] w_idx;

   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      gnt       = '0;
      w_rot     = '0;
      w_rot_gnt = '0;
      w_idx     = '0;
      for (int j = 0; j < 4; j++) begin
         w_idx    = 2'(j) + ptr;
         w_rot[j] = req[w_idx];
      end
      // x & -x isolates the lowest set bit, i.e. the first requester at or after ptr.
      w_rot_gnt = w_rot & (~w_rot + 4'd1);
      for (int j = 0; j < 4; j++) begin
         w_idx      = 2'(j) + ptr;
         gnt[w_idx] = w_rot_gnt[j];
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one of int/mul/div/ld-st each cycle, registers
// the winner's tag and data for broadcast, and returns the tag to the tag FIFO.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
   parameter int DATA_WIDTH = CDB_DATA_WIDTH,
   parameter int NUM_REQ    = CDB_NUM_REQ
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            flush,
   input  logic [NUM_REQ-1:0]              req_cdb,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]    tag_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_req,
   output logic [NUM_REQ-1:0]              gnt_cdb,
   output logic                            cdb_valid,
   output logic [TAG_WIDTH-1:0]            cdb_tag,
   output logic [DATA_WIDTH-1:0]           cdb_data,
   output logic [TAG_WIDTH-1:0]            cdb_tag_tf,
   output logic                            cdb_tag_tf_valid
);

   logic [1:0]            r_ptr;
   logic                  r_valid;
   logic [TAG_WIDTH-1:0]  r_tag;
   logic [DATA_WIDTH-1:0] r_data;

   logic [NUM_REQ-1:0]    w_req_arb;
   logic [NUM_REQ-1:0]    w_gnt;
   logic                  w_grant;
   logic [1:0]            w_win;
   logic [TAG_WIDTH-1:0]  w_tag;
   logic [DATA_WIDTH-1:0] w_data;

   // Masking the requests means a flushed request is never consumed and the pointer stays put.
   assign w_req_arb = (reset || flush) ? '0 : req_cdb;

   rr_arbiter4 u_rr (
      .req (w_req_arb),
      .ptr (r_ptr),
      .gnt (w_gnt)
   );

   assign gnt_cdb = w_gnt;
   assign w_grant = |w_gnt;
   assign w_win   = cdb_onehot_idx(w_gnt);

   always_comb begin
      w_tag  = '0;
      w_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_tag  = tag_req[i*TAG_WIDTH +: TAG_WIDTH];
            w_data = data_req[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else begin
         r_valid <= w_grant;
         if (w_grant) begin
            r_ptr  <= w_win + 2'd1;
            r_tag  <= w_tag;
            r_data <= w_data;
         end
      end
   end

   assign cdb_valid        = r_valid;
   assign cdb_tag          = r_tag;
   assign cdb_data         = r_data;
   assign cdb_tag_tf       = r_tag;
   assign cdb_tag_tf_valid = r_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized
// run against a behavioural round-robin model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int TW = CDB_TAG_WIDTH;
   localparam int DW = CDB_DATA_WIDTH;
   localparam int NR = CDB_NUM_REQ;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic [NR-1:0]    req_cdb;
   logic [NR*TW-1:0] tag_req;
   logic [NR*DW-1:0] data_req;
   logic [NR-1:0]    gnt_cdb;
   logic             cdb_valid;
   logic [TW-1:0]    cdb_tag;
   logic [DW-1:0]    cdb_data;
   logic [TW-1:0]    cdb_tag_tf;
   logic             cdb_tag_tf_valid;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int            m_ptr;
   logic          m_valid;
   logic [TW-1:0] m_tag;
   logic [DW-1:0] m_data;

   cdb_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .flush            (flush),
      .req_cdb          (req_cdb),
      .tag_req          (tag_req),
      .data_req         (data_req),
      .gnt_cdb          (gnt_cdb),
      .cdb_valid        (cdb_valid),
      .cdb_tag          (cdb_tag),
      .cdb_data         (cdb_data),
      .cdb_tag_tf       (cdb_tag_tf),
      .cdb_tag_tf_valid (cdb_tag_tf_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] model_gnt(input logic [3:0] r, input logic f, input int p);
      int idx;
      model_gnt = 4'b0000;
      if (!f) begin
         for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (r[idx]) begin
               model_gnt = 4'b0001 << idx;
               break;
            end
         end
      end
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 1'b0;
      m_tag   = '0;
      m_data  = '0;
   endtask

   task automatic model_edge(input logic [3:0] g);
      m_valid = |g;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) begin
            m_ptr  = (i + 1) % 4;
            m_tag  = tag_req[i*TW +: TW];
            m_data = data_req[i*DW +: DW];
         end
      end
   endtask

   task automatic set_unit(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d);
      tag_req[u*TW +: TW]  = t;
      data_req[u*DW +: DW] = d;
   endtask

   // Drive one cycle (entered and left 1 time unit after a rising edge).
   task automatic apply(input logic [3:0] r, input logic f,
                        output logic [3:0] g_seen, output logic [3:0] g_exp);
      req_cdb = r;
      flush   = f;
      #1;
      g_seen = gnt_cdb;
      g_exp  = model_gnt(r, f, m_ptr);
      @(posedge clk);
      model_edge(g_exp);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      flush   = 1'b0;
      req_cdb = 4'b1111;
      #1;
      checks++;
      if (gnt_cdb !== 4'b0000) begin
         errors++;
         $display("FAIL reset_gnt got %b want 0000", gnt_cdb);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({cdb_valid, cdb_tag, cdb_data, cdb_tag_tf_valid, cdb_tag_tf} !== '0) begin
         errors++;
         $display("FAIL reset_bus got v=%b tag=%0d data=%h tfv=%b tf=%0d want all 0",
                  cdb_valid, cdb_tag, cdb_data, cdb_tag_tf_valid, cdb_tag_tf);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_single();
      logic [3:0] gs, ge;
      set_unit(CDB_INT, 6'd5, 32'h0000_A5A5);
      apply(4'b0001, 1'b0, gs, ge);
      checks++;
      if (gs !== 4'b0001) begin
         errors++;
         $display("FAIL single_gnt got %b want 0001", gs);
      end
      checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 6'd5 || cdb_data !== 32'h0000_A5A5 ||
          cdb_tag_tf_valid !== 1'b1 || cdb_tag_tf !== 6'd5) begin
         errors++;
         $display("FAIL single_bus got v=%b tag=%0d data=%h tfv=%b tf=%0d want 1 5 0000a5a5 1 5",
                  cdb_valid, cdb_tag, cdb_data, cdb_tag_tf_valid, cdb_tag_tf);
      end
      // rr_ptr is now 1: with everyone requesting, unit 1 must win.
      apply(4'b1111, 1'b0, gs, ge);
      checks++;
      if (gs !== 4'b0010) begin
         errors++;
         $display("FAIL single_ptr_next got %b want 0010", gs);
      end
   endtask

   task automatic test_all_request();
      logic [3:0] gs, ge;
      pulse_reset();
      for (int i = 0; i < 4; i++) set_unit(i, TW'(i), DW'(32'h1000 + i));
      for (int c = 0; c < 4; c++) begin
         apply(4'b1111, 1'b0, gs, ge);
         checks++;
         if (gs !== (4'b0001 << c)) begin
            errors++;
            $display("FAIL all_req_gnt cycle %0d got %b want %b", c, gs, 4'b0001 << c);
         end
         checks++;
         if (cdb_valid !== 1'b1 || cdb_tag !== TW'(c) || cdb_data !== DW'(32'h1000 + c)) begin
            errors++;
            $display("FAIL all_req_bus cycle %0d got v=%b tag=%0d data=%h want tag %0d",
                     c, cdb_valid, cdb_tag, cdb_data, c);
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] gs, ge;
      apply(4'b0010, 1'b0, gs, ge);   // pointer moves to 2
      apply(4'b0011, 1'b0, gs, ge);
      checks++;
      if (gs !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_gnt got %b want 0001", gs);
      end
      apply(4'b0011, 1'b0, gs, ge);   // pointer now 1
      checks++;
      if (gs !== 4'b0010) begin
         errors++;
         $display("FAIL wrap_ptr_after got %b want 0010", gs);
      end
   endtask

   task automatic test_flush();
      logic [3:0] gs, ge;
      set_unit(CDB_MUL, 6'd17, 32'hDEAD_0001);
      set_unit(CDB_DIV, 6'd33, 32'hBEEF_0002);
      set_unit(CDB_INT, 6'd40, 32'hCAFE_0003);
      apply(4'b0010, 1'b0, gs, ge);   // pointer moves to 2, broadcast pending
      req_cdb = 4'b0100;
      flush   = 1'b1;
      #1;
      checks++;
      if (gnt_cdb !== 4'b0000) begin
         errors++;
         $display("FAIL flush_gnt got %b want 0000", gnt_cdb);
      end
      checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 6'd17) begin
         errors++;
         $display("FAIL flush_prev_visible got v=%b tag=%0d want 1 17", cdb_valid, cdb_tag);
      end
      @(posedge clk);
      model_edge(4'b0000);
      #1;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag_tf_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_valid got v=%b tfv=%b want 0 0", cdb_valid, cdb_tag_tf_valid);
      end
      // Pointer must still be 2: unit 2 beats unit 0.
      apply(4'b0101, 1'b0, gs, ge);
      checks++;
      if (gs !== 4'b0100) begin
         errors++;
         $display("FAIL flush_replay_gnt got %b want 0100", gs);
      end
      checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 6'd33 || cdb_data !== 32'hBEEF_0002) begin
         errors++;
         $display("FAIL flush_replay_bus got v=%b tag=%0d data=%h want 1 33 beef0002",
                  cdb_valid, cdb_tag, cdb_data);
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] gs, ge;
      set_unit(CDB_LS, 6'd21, 32'h1234_5678);
      apply(4'b1000, 1'b0, gs, ge);
      req_cdb = 4'b0000;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag_tf_valid !== 1'b0 || cdb_tag !== '0 || gnt_cdb !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset got v=%b tfv=%b tag=%0d gnt=%b want 0 0 0 0000",
                  cdb_valid, cdb_tag_tf_valid, cdb_tag, gnt_cdb);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      apply(4'b1111, 1'b0, gs, ge);
      checks++;
      if (gs !== 4'b0001) begin
         errors++;
         $display("FAIL async_reset_ptr got %b want 0001", gs);
      end
   endtask

   task automatic test_idle_hold();
      logic [3:0] gs, ge;
      set_unit(CDB_DIV, 6'd9, 32'h0000_0099);
      apply(4'b0100, 1'b0, gs, ge);
      apply(4'b0000, 1'b0, gs, ge);
      checks++;
      if (gs !== 4'b0000) begin
         errors++;
         $display("FAIL idle_gnt got %b want 0000", gs);
      end
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== 6'd9 || cdb_data !== 32'h0000_0099 ||
          cdb_tag_tf_valid !== 1'b0 || cdb_tag_tf !== 6'd9) begin
         errors++;
         $display("FAIL idle_hold got v=%b tag=%0d data=%h tfv=%b tf=%0d want 0 9 00000099 0 9",
                  cdb_valid, cdb_tag, cdb_data, cdb_tag_tf_valid, cdb_tag_tf);
      end
   endtask

   task automatic test_random();
      logic [3:0] pend, gs, ge;
      logic       f;
      int         wait_c[4];
      int         max_wait;
      pend     = 4'b0000;
      max_wait = 0;
      for (int i = 0; i < 4; i++) wait_c[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(1) == 1) begin
               pend[i] = 1'b1;
               set_unit(i, TW'($urandom), $urandom);
            end
         end
         f = ($urandom_range(7) == 0);
         apply(pend, f, gs, ge);
         checks++;
         if (gs !== ge) begin
            errors++;
            $display("FAIL rand_gnt cycle %0d got %b want %b", cyc, gs, ge);
         end
         checks++;
         if ({cdb_valid, cdb_tag, cdb_data, cdb_tag_tf_valid, cdb_tag_tf} !==
             {m_valid, m_tag, m_data, m_valid, m_tag}) begin
            errors++;
            $display("FAIL rand_bus cycle %0d got v=%b tag=%0d data=%h tfv=%b tf=%0d want v=%b tag=%0d data=%h",
                     cyc, cdb_valid, cdb_tag, cdb_data, cdb_tag_tf_valid, cdb_tag_tf,
                     m_valid, m_tag, m_data);
         end
         for (int i = 0; i < 4; i++) begin
            if (ge[i]) begin
               pend[i]   = 1'b0;
               wait_c[i] = 0;
            end else if (pend[i] && !f) begin
               wait_c[i]++;
               if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
         end
      end
      checks++;
      if (max_wait > 3) begin
         errors++;
         $display("FAIL rand_starvation got max wait %0d want <= 3", max_wait);
      end
   endtask

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      req_cdb  = '0;
      tag_req  = '0;
      data_req = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_all_request();
      test_wrap();
      test_flush();
      test_async_reset();
      test_idle_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the Common Data Bus (CDB) in the Tomasulo-style RISC-V core.
- Four execution units compete for the bus: integer ALU, multiplier, divider and load/store.
- Each cycle at most one winner is granted. Its tag and data are registered and broadcast on the CDB on the next cycle.
- The same registered tag is returned to the tag FIFO (free-tag list) through the cdb_tag_tf / cdb_tag_tf_valid ports.

Parameters:
- TAG_WIDTH, 6, width of a rename tag (must match the tag FIFO).
- DATA_WIDTH, 32, width of the result data.
- NUM_REQ, 4, number of requesters. Fixed at 4. Index map: 0=int, 1=mul, 2=div, 3=ld/st.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush (branch mispredict), synchronous.
- req_cdb  in  NUM_REQ  per-unit request; held high until granted.
- tag_req  in  NUM_REQ*TAG_WIDTH  packed tags; unit i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- data_req  in  NUM_REQ*DATA_WIDTH  packed result data, same packing as tag_req.
- gnt_cdb  out  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- cdb_valid  out  1  registered CDB broadcast valid.
- cdb_tag  out  TAG_WIDTH  registered broadcast tag.
- cdb_data  out  DATA_WIDTH  registered broadcast data.
- cdb_tag_tf  out  TAG_WIDTH  tag returned to the tag FIFO; equals cdb_tag.
- cdb_tag_tf_valid  out  1  tag-FIFO write enable; equals cdb_valid.

Behaviour:
- Reset (asynchronous):
  - rr_ptr=0.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_tag_tf=0, cdb_tag_tf_valid=0.
  - gnt_cdb=0 while reset is high.
- Arbitration (combinational):
  - Search req_cdb starting at index rr_ptr, ascending with wrap 3->0.
  - The first set bit wins, and only that bit of gnt_cdb is asserted.
  - No request: gnt_cdb=0.
  - flush=1: gnt_cdb=0 regardless of requests.
- Pointer update (clock edge):
  - If a grant is issued, rr_ptr <= winner+1 (mod 4).
  - Otherwise rr_ptr holds.
  - flush does not alter rr_ptr.
- Broadcast (clock edge):
  - If a grant is issued, cdb_valid<=1 and cdb_tag/cdb_data <= the winner's tag/data.
  - Otherwise cdb_valid<=0 and cdb_tag/cdb_data hold their previous values.
- Latency: request to broadcast is 1 cycle.
- Throughput: 1 broadcast per cycle. Any continuously requesting unit is served within 4 cycles (no starvation).
- Handshake:
  - A unit samples gnt_cdb in the same cycle and drops or advances its request at the next edge.
  - A request that is not granted must stay stable (req, tag, data).
- Flush:
  - On a flush cycle no grant is issued.
  - At the next edge cdb_valid<=0, so no tag is returned to the tag FIFO while it restores its defaults.
  - A broadcast already registered before the flush edge stays visible during the flush cycle. The consumer ignores it because flush is high.
- Simultaneous request and flush: flush wins; the request is not consumed and the unit must re-present it after the flush.
- Reset mid-broadcast: cdb_valid drops immediately (asynchronous); the pending result is discarded.
- cdb_tag_tf and cdb_tag_tf_valid are wire copies of cdb_tag and cdb_valid; there is no extra register stage.
- Width rule: rr_ptr is 2 bits and wraps naturally.

Decomposition:
- Shared package holds:
  - CDB_INT=0, CDB_MUL=1, CDB_DIV=2, CDB_LS=3.
  - TAG_WIDTH and DATA_WIDTH defaults, shared with the tag FIFO and reservation stations.
- One sub-module, rr_arbiter4: the combinational rotate/priority-find/rotate-back grant logic, taking req[3:0] and ptr[1:0] and producing a one-hot gnt[3:0].
- cdb_arbiter owns the pointer, the broadcast registers and the flush/reset handling.

Test Plan:
- Reset, then req_cdb=4'b0001 with tag_req[0]=6'd5, data_req[0]=32'hA5A5 -> gnt_cdb=0001 the same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=A5A5, cdb_tag_tf_valid=1; rr_ptr=1.
- req_cdb=4'b1111 held for 4 cycles starting from rr_ptr=0 -> gnt_cdb sequence 0001, 0010, 0100, 1000; 4 consecutive broadcasts carry tags 0,1,2,3.
- rr_ptr=2 with req_cdb=4'b0011 -> gnt_cdb=0001 (wrap 2->3->0); rr_ptr becomes 1.
- flush=1 with req_cdb=4'b0100 -> gnt_cdb=0; next cycle cdb_valid=0 and cdb_tag_tf_valid=0; rr_ptr unchanged; after the flush the request is granted on the first cycle it is presented.
- Assert reset asynchronously mid-cycle while cdb_valid=1 -> cdb_valid and cdb_tag_tf_valid go low before the next clock edge; rr_ptr=0.
- Idle cycle (req_cdb=0) after a broadcast of tag 9 -> cdb_valid=0 and cdb_tag stays 9; no tag-FIFO write.
